// File: rtl/alu_sum_datapath.sv
// Self-sequencing 16-bit ALU datapath: register file, ALU, immediate path and result bus.
// An embedded sequencer accumulates 1+2+...+N (mod 2^16) into R0 and then parks in DONE.
module alu_sum_datapath #(
    parameter int unsigned N = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] sum_out,
    output logic [15:0] bus_out,
    output logic [3:0]  flags,
    output logic        done
);

    // state | meaning
    // INIT0 | R0 <= MOV #0
    // INIT1 | R1 <= MOV #1
    // INIT2 | R2 <= MOV #N
    // ADD   | R0 <= R0 + R1
    // CMP   | CMP R1,R2; equal -> DONE else -> INC
    // INC   | R1 <= R1 + #1
    // DONE  | bus and writes idle, hold until reset
    typedef enum logic [2:0] {
        S_INIT0, S_INIT1, S_INIT2, S_ADD, S_CMP, S_INC, S_DONE
    } state_t;

    localparam logic [7:0]  OP_AND = 8'h01;
    localparam logic [7:0]  OP_OR  = 8'h02;
    localparam logic [7:0]  OP_XOR = 8'h03;
    localparam logic [7:0]  OP_ADD = 8'h05;
    localparam logic [7:0]  OP_SUB = 8'h09;
    localparam logic [7:0]  OP_CMP = 8'h0B;
    localparam logic [7:0]  OP_MOV = 8'h0D;
    localparam logic [15:0] N_IMM  = 16'(N);

    state_t      state, state_nxt;
    logic [15:0] regs [16];
    logic [15:0] enable;
    logic [4:0]  control1, control2;
    logic        imm_control;
    logic [15:0] imm;
    logic [7:0]  opcode;
    logic        buff_en;

    logic [15:0] op_a, op_b, alu_res;
    logic [16:0] alu_wide;
    logic        alu_c, alu_f, alu_z, upd_arith, upd_zn;
    logic [15:0] bus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT0: state_nxt = S_INIT1;
            S_INIT1: state_nxt = S_INIT2;
            S_INIT2: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_CMP;
            S_CMP:   state_nxt = alu_z ? S_DONE : S_INC;
            S_INC:   state_nxt = S_ADD;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_INIT0;
        endcase
    end

    // Control decode is kept apart from next-state so the CMP zero test is not a block-level loop.
    always_comb begin
        enable      = 16'h0000;
        control1    = 5'd16;
        control2    = 5'd16;
        imm_control = 1'b0;
        imm         = 16'h0000;
        opcode      = 8'h00;
        buff_en     = 1'b0;
        case (state)
            S_INIT0: begin
                enable = 16'h0001; imm_control = 1'b1; imm = 16'h0000;
                opcode = OP_MOV;   buff_en = 1'b1;
            end
            S_INIT1: begin
                enable = 16'h0002; imm_control = 1'b1; imm = 16'h0001;
                opcode = OP_MOV;   buff_en = 1'b1;
            end
            S_INIT2: begin
                enable = 16'h0004; imm_control = 1'b1; imm = N_IMM;
                opcode = OP_MOV;   buff_en = 1'b1;
            end
            S_ADD: begin
                enable = 16'h0001; control1 = 5'd0; control2 = 5'd1;
                opcode = OP_ADD;   buff_en = 1'b1;
            end
            S_CMP: begin
                control1 = 5'd1; control2 = 5'd2;
                opcode   = OP_CMP; buff_en = 1'b1;
            end
            S_INC: begin
                enable = 16'h0002; control1 = 5'd1; imm_control = 1'b1; imm = 16'h0001;
                opcode = OP_ADD;   buff_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_a = control1[4] ? 16'h0000 : regs[control1[3:0]];
    assign op_b = imm_control ? imm : (control2[4] ? 16'h0000 : regs[control2[3:0]]);

    always_comb begin
        alu_wide  = 17'd0;
        alu_res   = 16'h0000;
        alu_c     = 1'b0;
        alu_f     = 1'b0;
        upd_arith = 1'b0;
        upd_zn    = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_wide  = {1'b0, op_a} + {1'b0, op_b};
                alu_res   = alu_wide[15:0];
                alu_c     = alu_wide[16];
                alu_f     = (op_a[15] == op_b[15]) && (alu_res[15] != op_a[15]);
                upd_arith = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_wide  = {1'b0, op_a} - {1'b0, op_b};
                alu_res   = alu_wide[15:0];
                alu_c     = alu_wide[16];
                alu_f     = (op_a[15] != op_b[15]) && (alu_res[15] != op_a[15]);
                upd_arith = 1'b1;
            end
            OP_AND: begin alu_res = op_a & op_b; upd_zn = 1'b1; end
            OP_OR:  begin alu_res = op_a | op_b; upd_zn = 1'b1; end
            OP_XOR: begin alu_res = op_a ^ op_b; upd_zn = 1'b1; end
            OP_MOV: begin alu_res = op_b;        upd_zn = 1'b1; end
            default: ;
        endcase
    end

    assign alu_z   = (alu_res == 16'h0000);
    assign bus     = buff_en ? alu_res : 16'h0000;
    assign bus_out = reset ? 16'h0000 : bus;

    // CMP result is never written back; its enable stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            flags <= 4'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (enable[i]) regs[i] <= bus;
            end
            if (upd_arith)   flags      <= {alu_c, alu_f, alu_z, alu_res[15]};
            else if (upd_zn) flags[1:0] <= {alu_z, alu_res[15]};
        end
    end

    assign sum_out = regs[0];
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_alu_sum_datapath.sv
// Bench for alu_sum_datapath: three instances (N=10, 1, 400) compared every cycle against
// an arithmetic model of the summation program, with randomly placed mid-loop resets.
module tb_alu_sum_datapath;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] s10, b10, s1, b1, s400, b400;
    logic [3:0]  f10, f1, f400;
    logic        d10, d1, d400;

    alu_sum_datapath #(.N(10))  u_n10  (.clk(clk), .reset(reset), .sum_out(s10),  .bus_out(b10),  .flags(f10),  .done(d10));
    alu_sum_datapath #(.N(1))   u_n1   (.clk(clk), .reset(reset), .sum_out(s1),   .bus_out(b1),   .flags(f1),   .done(d1));
    alu_sum_datapath #(.N(400)) u_n400 (.clk(clk), .reset(reset), .sum_out(s400), .bus_out(b400), .flags(f400), .done(d400));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int e, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
        end
    endtask

    // 1+2+...+k modulo 2^16
    function automatic logic [15:0] tri16(input longint k);
        return 16'(((k * (k + 1)) / 2) % 65536);
    endfunction

    // {C,F,Z,N,result} of a 16-bit add or subtract
    function automatic logic [19:0] arith(input int a, input int b, input bit sub);
        int r, sa, sb, sr;
        logic [15:0] r16;
        logic c, f;
        r   = sub ? a - b : a + b;
        r16 = 16'(r);
        sa  = (a >= 32768) ? a - 65536 : a;
        sb  = (b >= 32768) ? b - 65536 : b;
        sr  = sub ? sa - sb : sa + sb;
        c   = sub ? (a < b) : (r > 65535);
        f   = (sr > 32767) || (sr < -32768);
        return {c, f, (r16 == 16'h0000), r16[15], r16};
    endfunction

    // Flags after, and bus value during, program step s (1-based) of the summation
    function automatic logic [19:0] step_out(input int n, input int s);
        int k, ph;
        logic [15:0] n16;
        n16 = 16'(n);
        if (s == 1) return {4'b0010, 16'h0000};
        if (s == 2) return {4'b0000, 16'h0001};
        if (s == 3) return {2'b00, (n16 == 16'h0000), n16[15], n16};
        k  = (s - 4) / 3 + 1;
        ph = (s - 4) % 3;
        if (ph == 0) return arith(int'(tri16(k - 1)), k, 1'b0);
        if (ph == 1) return arith(k, n, 1'b1);
        return arith(k, 1, 1'b0);
    endfunction

    task automatic check_inst(input string pfx, input int n, input int e,
                              input logic [15:0] sm, input logic [15:0] bs,
                              input logic [3:0] fl, input logic dn);
        int adds;
        if (e >= 3 * n + 2) begin
            check({pfx, "_sum"},   e, sm, tri16(n));
            check({pfx, "_bus"},   e, bs, 16'h0000);
            check({pfx, "_flags"}, e, {12'h000, fl}, 16'h0002);
            check({pfx, "_done"},  e, {15'h0000, dn}, 16'h0001);
        end else begin
            adds = (e < 4) ? 0 : (e - 4) / 3 + 1;
            check({pfx, "_sum"},   e, sm, tri16(adds));
            check({pfx, "_bus"},   e, bs, step_out(n, e + 1));
            check({pfx, "_flags"}, e, {12'h000, fl},
                  (e == 0) ? 16'h0000 : {12'h000, step_out(n, e)[19:16]});
            check({pfx, "_done"},  e, {15'h0000, dn}, 16'h0000);
        end
    endtask

    task automatic check_all(input int e);
        check_inst("n10",  10,  e, s10,  b10,  f10,  d10);
        check_inst("n1",   1,   e, s1,   b1,   f1,   d1);
        check_inst("n400", 400, e, s400, b400, f400, d400);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_n10_sum"},  0, s10,  16'h0000);
        check({tag, "_n10_bus"},  0, b10,  16'h0000);
        check({tag, "_n10_flg"},  0, {12'h000, f10}, 16'h0000);
        check({tag, "_n10_done"}, 0, {15'h0000, d10}, 16'h0000);
        check({tag, "_n1_sum"},   0, s1,   16'h0000);
        check({tag, "_n1_done"},  0, {15'h0000, d1}, 16'h0000);
        check({tag, "_n400_sum"}, 0, s400, 16'h0000);
        check({tag, "_n400_bus"}, 0, b400, 16'h0000);
    endtask

    // Called at a falling edge right after reset release; samples each following falling edge.
    task automatic run_from_release(input int edges);
        #1;
        check_all(0);
        @(negedge clk);
        for (int e = 1; e <= edges; e++) begin
            check_all(e);
            if (e < edges) @(negedge clk);
        end
    endtask

    task automatic reset_pulse(input string tag);
        int hold;
        #2;
        reset = 1'b1;
        #1;
        check_reset(tag);
        hold = int'($urandom_range(3, 1));
        repeat (hold) @(negedge clk);
        check_reset({tag, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        int mid;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("por");
        reset = 1'b0;
        run_from_release(1230);

        for (int rep = 0; rep < 2; rep++) begin
            reset_pulse("rst");
            mid = int'($urandom_range(30, 5));
            run_from_release(mid);
            reset_pulse("midloop");
            run_from_release(1230);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
